// File: rtl/wb_pkg.sv
// wb_pkg -- shared types and defaults for the writeback arbiter.
//   wb_src_e     : writeback source select encoding (ALU=0, MEM=1)
//   prio_state_e : conflict-priority owner
//   WB_DATA_W / WB_REG_AW : default data and register-address widths
package wb_pkg;
   localparam int WB_DATA_W = 16;
   localparam int WB_REG_AW = 4;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_MEM = 1'b1
   } wb_src_e;

   typedef enum logic {
      PRIO_MEM = 1'b0,
      PRIO_ALU = 1'b1
   } prio_state_e;
endpackage

// File: rtl/wb_hold_buf.sv
// wb_hold_buf -- single-entry holding buffer with valid/ready input side.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   in_valid/in_data/in_rd   : producer side; ready is the back-pressure
//   grant                    : buffer entry consumed this cycle
//   full, data, rd           : current buffer contents
// A granted entry may be replaced in the same cycle (drain and refill).
module wb_hold_buf #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              grant,
   output logic              ready,
   output logic              full,
   output logic [DATA_W-1:0] data,
   output logic [REG_AW-1:0] rd
);
   assign ready = !full || grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
         data <= '0;
         rd   <= '0;
      end else if (in_valid && ready) begin
         full <= 1'b1;
         data <= in_data;
         rd   <= in_rd;
      end else if (grant) begin
         full <= 1'b0;
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter -- arbitrates ALU results and load data onto one register-file
// write port.
// Ports:
//   clk, rst                        : clock, async active-high reset
//   alu_valid/alu_ready/alu_data/alu_rd : ALU result handshake
//   mem_valid/mem_ready/mem_data/mem_rd : load result handshake
//   rf_we/rf_waddr/rf_wdata/wb_sel  : registered RF write port and mux select
//   stall                           : a full buffer is waiting this cycle
// Configuration macro WB_FAIR_EN: when defined, the ALU is promoted to
// conflict priority after STARVE_MAX consecutive conflict losses; otherwise
// MEM always wins conflicts.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W     = WB_DATA_W,
   parameter int REG_AW     = WB_REG_AW,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [REG_AW-1:0] mem_rd,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              wb_sel,
   output logic              stall
);
   logic              alu_full, mem_full;
   logic [DATA_W-1:0] alu_buf_data, mem_buf_data;
   logic [REG_AW-1:0] alu_buf_rd, mem_buf_rd;
   logic              grant_alu, grant_mem;
   prio_state_e       state, state_nxt;
   wb_src_e           sel_q;

   wb_hold_buf #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_alu_buf (
      .clk(clk), .rst(rst),
      .in_valid(alu_valid), .in_data(alu_data), .in_rd(alu_rd),
      .grant(grant_alu), .ready(alu_ready),
      .full(alu_full), .data(alu_buf_data), .rd(alu_buf_rd)
   );

   wb_hold_buf #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mem_buf (
      .clk(clk), .rst(rst),
      .in_valid(mem_valid), .in_data(mem_data), .in_rd(mem_rd),
      .grant(grant_mem), .ready(mem_ready),
      .full(mem_full), .data(mem_buf_data), .rd(mem_buf_rd)
   );

   // A lone full buffer always wins; priority state only breaks conflicts.
   assign grant_alu = alu_full && (!mem_full || (state == PRIO_ALU));
   assign grant_mem = mem_full && !grant_alu;
   assign stall     = (alu_full && !grant_alu) || (mem_full && !grant_mem);
   assign wb_sel    = sel_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         sel_q    <= WB_SRC_ALU;
      end else begin
         rf_we <= grant_alu || grant_mem;
         if (grant_alu) begin
            rf_waddr <= alu_buf_rd;
            rf_wdata <= alu_buf_data;
            sel_q    <= WB_SRC_ALU;
         end else if (grant_mem) begin
            rf_waddr <= mem_buf_rd;
            rf_wdata <= mem_buf_data;
            sel_q    <= WB_SRC_MEM;
         end
      end
   end

`ifdef WB_FAIR_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= PRIO_MEM;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;
      case (state)
         PRIO_MEM: begin
            if (grant_alu) begin
               starve_cnt_nxt = '0;
            end else if (alu_full && mem_full) begin
               // ALU lost a conflict; saturate and hand over priority at max.
               if (starve_cnt != CNT_MAX) starve_cnt_nxt = starve_cnt + 1'b1;
               if (starve_cnt_nxt == CNT_MAX) state_nxt = PRIO_ALU;
            end
         end
         PRIO_ALU: begin
            if (grant_alu) begin
               state_nxt      = PRIO_MEM;
               starve_cnt_nxt = '0;
            end
         end
         default: state_nxt = PRIO_MEM;
      endcase
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= PRIO_MEM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = PRIO_MEM;
   end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter -- self-checking bench for wb_arbiter: reset state, a vector
// table of directed cases, fairness grant order, reset mid-operation and a
// randomized run against a behavioural model of the arbitration rules.
module tb_wb_arbiter;
   localparam int STARVE = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0, mem_valid = 1'b0;
   logic [15:0] alu_data = '0, mem_data = '0;
   logic [3:0]  alu_rd = '0, mem_rd = '0;
   logic        alu_ready, mem_ready, rf_we, wb_sel, stall;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;

   wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_rd(alu_rd),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data), .mem_rd(mem_rd),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_sel(wb_sel),
      .stall(stall)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: each requester holds at most one pending entry.
   logic        m_af, m_mf;
   logic [15:0] m_ad, m_md;
   logic [3:0]  m_ard, m_mrd;
   logic        m_we, m_sel;
   logic [3:0]  m_waddr;
   logic [15:0] m_wdata;
   int          losses;
   logic        owed;
   logic [15:0] regf [16];

   // obs layout: {alu_ready, mem_ready, stall, rf_we, wb_sel, rf_waddr, rf_wdata}
   typedef struct packed {
      logic        av;
      logic [15:0] ad;
      logic [3:0]  ard;
      logic        mv;
      logic [15:0] md;
      logic [3:0]  mrd;
      logic [24:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mreset();
      m_af = 0; m_mf = 0; m_ad = '0; m_md = '0; m_ard = '0; m_mrd = '0;
      m_we = 0; m_sel = 0; m_waddr = '0; m_wdata = '0;
      losses = 0; owed = 0;
   endtask

   function automatic logic [24:0] pack(input logic ar, mr, st, we, sel,
                                        input logic [3:0] wa, input logic [15:0] wd);
      return {ar, mr, st, we, sel, wa, wd};
   endfunction

   // One clock cycle: drive inputs at negedge, check, then advance the model.
   task automatic step(input logic av, input logic [15:0] ad, input logic [3:0] ard,
                       input logic mv, input logic [15:0] md, input logic [3:0] mrd,
                       output logic [24:0] obs);
      logic ga, gm;
      alu_valid = av; alu_data = ad; alu_rd = ard;
      mem_valid = mv; mem_data = md; mem_rd = mrd;
      #1;
      ga = m_af && (!m_mf || owed);
      gm = m_mf && !ga;
      obs = pack(alu_ready, mem_ready, stall, rf_we, wb_sel, rf_waddr, rf_wdata);
      chk("model", 32'(obs),
          32'(pack(!m_af || ga, !m_mf || gm, (m_af && !ga) || (m_mf && !gm),
                   m_we, m_sel, m_waddr, m_wdata)));
      if (rf_we) regf[rf_waddr] = rf_wdata;
      @(posedge clk);
      m_we = ga || gm;
      if (ga) begin m_sel = 0; m_waddr = m_ard; m_wdata = m_ad; end
      else if (gm) begin m_sel = 1; m_waddr = m_mrd; m_wdata = m_md; end
`ifdef WB_FAIR_EN
      if (ga) begin losses = 0; owed = 0; end
      else if (gm && m_af) begin
         losses++;
         if (losses >= STARVE) owed = 1;
      end
`endif
      if (av && (!m_af || ga)) begin m_af = 1; m_ad = ad; m_ard = ard; end
      else if (ga) m_af = 0;
      if (mv && (!m_mf || gm)) begin m_mf = 1; m_md = md; m_mrd = mrd; end
      else if (gm) m_mf = 0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      logic [24:0] o;
      for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, o);
   endtask

   vec_t        tv [17];
   logic [24:0] obs;
   logic [7:0]  pat, pat_exp;
   int          np;

   initial begin
      for (int i = 0; i < 16; i++) regf[i] = '0;
      mreset();

      // Directed vectors: inputs of a cycle and outputs observed in that cycle.
      tv[0]  = '{1'b1, 16'h00A5, 4'd3, 1'b0, 16'h0000, 4'd0, pack(1,1,0,0,0,4'd0,16'h0000)};
      tv[1]  = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(1,1,0,0,0,4'd0,16'h0000)};
      tv[2]  = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(1,1,0,1,0,4'd3,16'h00A5)};
      tv[3]  = '{1'b1, 16'h1111, 4'd1, 1'b1, 16'h2222, 4'd2, pack(1,1,0,0,0,4'd3,16'h00A5)};
      tv[4]  = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(0,1,1,0,0,4'd3,16'h00A5)};
      tv[5]  = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(1,1,0,1,1,4'd2,16'h2222)};
      tv[6]  = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(1,1,0,1,0,4'd1,16'h1111)};
      tv[7]  = '{1'b1, 16'h0001, 4'd4, 1'b0, 16'h0000, 4'd0, pack(1,1,0,0,0,4'd1,16'h1111)};
      tv[8]  = '{1'b1, 16'h0002, 4'd5, 1'b0, 16'h0000, 4'd0, pack(1,1,0,0,0,4'd1,16'h1111)};
      tv[9]  = '{1'b1, 16'h0003, 4'd6, 1'b0, 16'h0000, 4'd0, pack(1,1,0,1,0,4'd4,16'h0001)};
      tv[10] = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(1,1,0,1,0,4'd5,16'h0002)};
      tv[11] = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(1,1,0,1,0,4'd6,16'h0003)};
      tv[12] = '{1'b1, 16'hBBBB, 4'd5, 1'b1, 16'hAAAA, 4'd5, pack(1,1,0,0,0,4'd6,16'h0003)};
      tv[13] = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(0,1,1,0,0,4'd6,16'h0003)};
      tv[14] = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(1,1,0,1,1,4'd5,16'hAAAA)};
      tv[15] = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(1,1,0,1,0,4'd5,16'hBBBB)};
      tv[16] = '{1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 4'd0, pack(1,1,0,0,0,4'd5,16'hBBBB)};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", 32'(pack(alu_ready, mem_ready, stall, rf_we, wb_sel, rf_waddr, rf_wdata)),
          32'(pack(1,1,0,0,0,4'd0,16'h0000)));
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         step(tv[i].av, tv[i].ad, tv[i].ard, tv[i].mv, tv[i].md, tv[i].mrd, obs);
         chk($sformatf("vec%0d", i), 32'(obs), 32'(tv[i].exp));
      end
      chk("same_rd_final", 32'(regf[5]), 32'h0000BBBB);

      // Grant order with both requesters valid every cycle
      rst = 1'b1; #1; rst = 1'b0; mreset(); @(negedge clk);
      pat = '0; np = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 16'h1000 + 16'(i), 4'd9, 1, 16'h2000 + 16'(i), 4'd10, obs);
         if (obs[21] && np < 8) begin pat[np] = obs[20]; np++; end
      end
`ifdef WB_FAIR_EN
      pat_exp = 8'b0111_0111;
`else
      pat_exp = 8'hFF;
`endif
      chk("grant_order", {24'd0, pat}, {24'd0, pat_exp});
      chk("grant_count", 32'(np), 32'd8);
      idle(4);

      // Reset while both buffers are full
      step(1, 16'h7777, 4'd7, 1, 16'h8888, 4'd8, obs);
      rst = 1'b1; #1;
      chk("reset_midop", 32'(pack(0,0,stall,rf_we,wb_sel,rf_waddr,rf_wdata)), 32'd0);
      alu_valid = 0; mem_valid = 0;
      @(negedge clk);
      rst = 1'b0; mreset();
      #1;
      chk("post_reset_ready", {29'd0, alu_ready, mem_ready, stall}, 32'b110);
      @(negedge clk);
      np = 0;
      for (int i = 0; i < 3; i++) begin
         step(0, '0, '0, 0, '0, '0, obs);
         if (obs[21]) np++;
      end
      chk("no_we_after_reset", 32'(np), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom),
              $urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), obs);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, writeback data width.
REQ-002 SHALL have parameter REG_AW, default 4, register-file address width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, consecutive ALU losses before ALU priority.
REQ-004 SHALL have clk  input  1  sole clock, rising-edge.
REQ-005 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have alu_valid  input  1 / alu_ready  output  1  ALU result handshake.
REQ-007 SHALL have alu_data  input  DATA_W / alu_rd  input  REG_AW  ALU result and destination.
REQ-008 SHALL have mem_valid  input  1 / mem_ready  output  1  load-result handshake.
REQ-009 SHALL have mem_data  input  DATA_W / mem_rd  input  REG_AW  load data and destination.
REQ-010 SHALL have rf_we  output  1 / rf_waddr  output  REG_AW / rf_wdata  output  DATA_W  registered register-file write port.
REQ-011 SHALL have wb_sel  output  1  writeback mux select: 0 = ALU, 1 = MEM, registered, aligned with rf_we.
REQ-012 SHALL have stall  output  1  high while any holding buffer is full and not granted this cycle.

Function
REQ-013 SHALL hold one single-entry buffer per requester (ALU, MEM): data, rd, full flag.
REQ-014 SHALL accept a transfer at a rising edge when valid && ready; ready = !full || (buffer granted this cycle).
REQ-015 SHALL permit same-cycle drain and refill of one buffer with no bubble.
REQ-016 SHALL grant at most one full buffer per cycle; the granted entry appears on rf_* at the next edge (latency: accept edge N -> rf_we high during cycle after edge N+1).
REQ-017 SHALL drive rf_we low, and hold rf_waddr/rf_wdata/wb_sel at their last values, in cycles with no grant.
REQ-018 SHALL grant the only full buffer when just one is full, independent of priority state.
REQ-019 SHALL run a 2-state priority FSM: PRIO_MEM (reset state), PRIO_ALU; on conflict (both full) the state's owner wins.
REQ-020 SHALL, in PRIO_MEM, increment starve_cnt on every conflict lost by ALU, clear it on any ALU grant, and move to PRIO_ALU when starve_cnt reaches STARVE_MAX.
REQ-021 SHALL, in PRIO_ALU, return to PRIO_MEM immediately after the next ALU grant, with starve_cnt cleared.
REQ-022 SHALL saturate starve_cnt at STARVE_MAX; width = $clog2(STARVE_MAX+1).
REQ-023 SHALL NOT reorder or merge entries with equal rd; each accepted entry produces exactly one rf_we pulse.
REQ-024 SHALL assert stall combinationally from current full flags and grant.

Reset
REQ-025 SHALL, on rst high, asynchronously clear both full flags, rf_we=0, rf_waddr=0, rf_wdata=0, wb_sel=0, starve_cnt=0, FSM=PRIO_MEM.
REQ-026 SHALL discard buffered entries on reset mid-operation; no rf_we pulse for them after release.
REQ-027 SHALL drive alu_ready=mem_ready=1 and stall=0 in the first cycle after reset release.

Configuration
REQ-028 SHALL, with WB_FAIR_EN defined, implement REQ-020..022 fairness.
REQ-029 SHALL, without WB_FAIR_EN, remain in PRIO_MEM permanently with no starve counter logic (MEM always wins conflicts).

Structure
REQ-030 SHALL take wb_src_e (WB_SRC_ALU=0, WB_SRC_MEM=1), prio_state_e, and default DATA_W/REG_AW from shared package wb_pkg.
REQ-031 SHALL instantiate sub-module wb_hold_buf (single-entry holding buffer) once per requester.

Verification
REQ-032 SHALL cover: ALU only, alu_data=16'h00A5, rd=3 -> one cycle later rf_we=1, rf_waddr=3, rf_wdata=16'h00A5, wb_sel=0.
REQ-033 SHALL cover: ALU rd=1 16'h1111 and MEM rd=2 16'h2222 same edge -> MEM written first (wb_sel=1), ALU next cycle; stall=1 for one cycle.
REQ-034 SHALL cover (WB_FAIR_EN): both valid continuously -> grant order MEM,MEM,MEM,ALU repeating; without macro -> ALU never granted until mem_valid drops.
REQ-035 SHALL cover: ALU back-to-back 3 transfers, no MEM -> alu_ready stays 1, three consecutive rf_we pulses, no bubble.
REQ-036 SHALL cover: rst asserted while both buffers full -> all outputs zero immediately, no rf_we after release.
REQ-037 SHALL cover: MEM and ALU both target rd=5 (16'hAAAA, 16'hBBBB) -> two rf_we pulses, final register value 16'hBBBB.
